time_digit_pair_n: RTL
======================

Name: time_digit_pair_n

Overview:
- Parametrised two-digit BCD time counter with seven-segment outputs and carry chaining.
- Generalises the fixed seconds stage: modulus-N (60 for sec/min, 24/12 for hours), up/down counting, set mode with increment and blink, synchronous clear.
- Runs on the single system clock using tick enables, not derived clocks; stages chain through carry_out -> carry_in.

Parameters:
- CLK_DIV, 1000: clk cycles per count when EXT_TICK=0; legal range 2..65535.
- MODULUS, 60: count range 0..MODULUS-1; legal range 2..100.
- EXT_TICK, 0: 0 = internal prescaler is the tick source; 1 = carry_in is the tick source.
- BLINK_DIV, 500: clk cycles per half-period of the set-mode blink; legal range >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  count enable; also gates the prescaler.
- up_dn  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear to 00.
- set_mode  in  1  1 = time-set mode.
- inc  in  1  single-cycle pulse; increments value while in set mode.
- carry_in  in  1  single-cycle tick from the lower stage; used only when EXT_TICK=1.
- carry_out  out  1  single-cycle wrap/borrow pulse.
- bcd_1  out  4  units digit.
- bcd_10  out  4  tens digit.
- seg_data_1  out  8  seven-segment pattern for the units digit.
- seg_data_10  out  8  seven-segment pattern for the tens digit.

Behaviour:
- Reset (rst=0, async): digits=0; prescaler=0; blink counter=0; blink phase=visible; carry_out=0; seg_data_1 and seg_data_10 = 8'hFC.
- Tick:
  - EXT_TICK=0: prescaler counts 0..CLK_DIV-1 while en=1 and set_mode=0; tick = (prescaler==CLK_DIV-1); prescaler then wraps to 0.
  - EXT_TICK=0, en=0: prescaler holds its value.
  - EXT_TICK=1: tick = carry_in & en & ~set_mode.
  - Prescaler in set mode or clr: forced to 0.
- Priority per edge: clr > set_mode > tick.
- clr: digits <- 0 next edge; carry_out=0; prescaler=0.
- Set mode:
  - Counting stops.
  - inc=1 adds 1 with wrap MODULUS-1 -> 0.
  - Set-mode increments never assert carry_out.
- Up count on tick: value+1; at MODULUS-1 wraps to 0 and asserts carry_out.
- Down count on tick: value-1; at 0 wraps to MODULUS-1 and asserts carry_out (borrow).
- carry_out timing: registered; high for exactly one cycle, the cycle in which the new wrapped value is visible.
- Digit arithmetic: BCD internally; units 0..9 rolls into tens. Value = 10*bcd_10 + bcd_1 and is never >= MODULUS.
- MODULUS not a multiple of 10 (e.g. 24): up from 23 -> 00; down from 00 -> 23.
- Latency: with EXT_TICK=0 and en high from reset release, the first value change is visible after CLK_DIV rising edges.
- Blink:
  - In set mode, the blink counter toggles phase every BLINK_DIV cycles; both seg outputs = 8'h00 in the blanked phase.
  - On entering set mode, phase starts visible.
  - Outside set mode, phase is forced visible and the counter is held at 0.
- Segment encoding: combinational from the digit registers, active-high, bit7..0 = a,b,c,d,e,f,g,dp; dp always 0.
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6.
  - Digit codes >9 are unreachable; decode them to 00.
- up_dn change takes effect on the next tick; the prescaler is not reset.
- Reset asserted mid-count: all state clears immediately, with no carry glitch on release.

Test Plan:
- CLK_DIV=4, MODULUS=60, en=1, up_dn=1 from reset -> first increment after 4 edges; 59->00 with carry_out high one cycle; seg_data_10=FC, seg_data_1=FC after wrap.
- MODULUS=24, up_dn=0, start 00 -> next tick gives 23 (bcd_10=2, bcd_1=3, seg DA/F2) and carry_out pulse; 10->09 gives tens borrow only, no carry_out.
- EXT_TICK=1: inject carry_in pulses with en=0 then en=1 -> value changes only for pulses with en=1; a carry_in pulse coincident with clr -> result 00, no carry_out.
- set_mode=1 at value 58, three inc pulses -> 59, 00, 01 with no carry_out; segments blank every BLINK_DIV (set 3) cycles; exit set mode -> display steady, counting resumes from 01 after CLK_DIV edges.
- Simultaneous tick and set_mode rising in the same cycle -> value unchanged, no carry_out.
- Assert rst low mid-prescale at value 37 -> outputs immediately 00 / FC / FC, carry_out 0; after release, full CLK_DIV edges to first tick.

Source files
------------

// File: rtl/time_digit_pair_n.sv
// Two-digit BCD time counter stage (modulus-N) with seven-segment outputs,
// set-mode editing with blink, and carry chaining through single-cycle ticks.
module time_digit_pair_n #(
  parameter int CLK_DIV   = 1000,
  parameter int MODULUS   = 60,
  parameter int EXT_TICK  = 0,
  parameter int BLINK_DIV = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up_dn,
  input  logic       clr,
  input  logic       set_mode,
  input  logic       inc,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [3:0] bcd_1,
  output logic [3:0] bcd_10,
  output logic [7:0] seg_data_1,
  output logic [7:0] seg_data_10
);

  localparam int PW = 16;
  localparam int BW = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    MAX_TENS   = 4'((MODULUS - 1) / 10);
  localparam logic [3:0]    MAX_UNITS  = 4'((MODULUS - 1) % 10);

  logic [PW-1:0] prescaler;
  logic [BW-1:0] blink_cnt;
  logic          blink_vis;
  logic          tick;
  logic          at_max;
  logic          at_zero;
  logic [3:0]    up_tens, up_units;
  logic [3:0]    dn_tens, dn_units;

  always_comb begin
    if (EXT_TICK != 0) tick = carry_in & en & ~set_mode;
    else               tick = en & ~set_mode & (prescaler == PRE_LAST);
  end

  // Successor/predecessor values in BCD, with wrap at the modulus limits.
  always_comb begin
    at_max   = (bcd_10 == MAX_TENS) && (bcd_1 == MAX_UNITS);
    at_zero  = (bcd_10 == 4'd0) && (bcd_1 == 4'd0);
    up_tens  = bcd_10;
    up_units = bcd_1 + 4'd1;
    dn_tens  = bcd_10;
    dn_units = bcd_1 - 4'd1;
    if (at_max) begin
      up_tens  = 4'd0;
      up_units = 4'd0;
    end else if (bcd_1 == 4'd9) begin
      up_tens  = bcd_10 + 4'd1;
      up_units = 4'd0;
    end
    if (at_zero) begin
      dn_tens  = MAX_TENS;
      dn_units = MAX_UNITS;
    end else if (bcd_1 == 4'd0) begin
      dn_tens  = bcd_10 - 4'd1;
      dn_units = 4'd9;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
    end else if (clr || set_mode) begin
      prescaler <= '0;
    end else if (en) begin
      prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_1     <= 4'd0;
      bcd_10    <= 4'd0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (clr) begin
        bcd_1  <= 4'd0;
        bcd_10 <= 4'd0;
      end else if (set_mode) begin
        if (inc) begin
          bcd_1  <= up_units;
          bcd_10 <= up_tens;
        end
      end else if (tick) begin
        if (up_dn) begin
          bcd_1     <= up_units;
          bcd_10    <= up_tens;
          carry_out <= at_max;
        end else begin
          bcd_1     <= dn_units;
          bcd_10    <= dn_tens;
          carry_out <= at_zero;
        end
      end
    end
  end

  // Blink runs only in set mode and always restarts in the visible phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (!set_mode) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_vis <= ~blink_vis;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hFC;
      4'd1:    seg_of = 8'h60;
      4'd2:    seg_of = 8'hDA;
      4'd3:    seg_of = 8'hF2;
      4'd4:    seg_of = 8'h66;
      4'd5:    seg_of = 8'hB6;
      4'd6:    seg_of = 8'hBE;
      4'd7:    seg_of = 8'hE0;
      4'd8:    seg_of = 8'hFE;
      4'd9:    seg_of = 8'hF6;
      default: seg_of = 8'h00;
    endcase
  endfunction

  always_comb begin
    seg_data_1  = blink_vis ? seg_of(bcd_1)  : 8'h00;
    seg_data_10 = blink_vis ? seg_of(bcd_10) : 8'h00;
  end

endmodule
